uart_tx_frame: RTL and testbench

Serial UART transmitter for the oversampled serial link. It serialises one parallel byte into a frame: start bit, data bits LSB first, optional even-parity bit, then stop bit. Each bit is held for a fixed number of `clk_br` cycles. It runs on the same baud-oversampling clock as the companion receiver, so the two can be looped back for bench checks.

---
 rtl/uart_tx_frame.sv | 140 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// UART frame serialiser: start, DATA_BITS LSB first, even parity if UART_TX_PARITY_EN is defined, stop.
// Latency: tx drops to the start bit on the edge after load is sampled; done lands (2+DATA_BITS[+1])*CLKS_PER_BIT cycles later.
// Backpressure: load is accepted only while busy=0; load while busy is dropped, never queued.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 20,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_br,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

    state_t               state;
    logic [7:0]           cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    // tx is registered, so each transition loads the level of the bit being entered.
    always_ff @(posedge clk_br) begin
        if (rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= 8'd0;
            idx   <= 4'd0;
            shift <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (load) begin
                        shift <= data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^data;
`endif
                        cnt   <= 8'd0;
                        idx   <= 4'd0;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= 8'd0;
                        state <= DATA;
                        tx    <= shift[0];
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= 8'd0;
                        shift <= shift >> 1;
                        if (idx == LAST_IDX) begin
                            idx <= 4'd0;
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            idx <= idx + 4'd1;
                            tx  <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= 8'd0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (cnt == LAST_CNT) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= 8'd0;
                    idx   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_frame at default parameters; bit levels are sampled mid-bit.
module tb_uart_tx_frame;

    localparam int CPB = 20;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk_br = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [10:0] bits;
    int          done_j;
    int          ndone;
    int          bad;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk_br (clk_br),
        .rst    (rst),
        .load   (load),
        .data   (data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk_br = ~clk_br;

    task automatic step();
        @(posedge clk_br);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels, index 0 = start bit, LSB first, idle-high padding above the stop bit.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    // Starts on the cycle right after the accepting edge (j=0); ends on cycle j=max without stepping past it.
    task automatic capture(input int max, input int poke_j, input logic [7:0] poke_d,
                           output logic [10:0] b, output int dj, output int nd);
        b  = '1;
        dj = -1;
        nd = 0;
        for (int j = 0; j <= max; j++) begin
            if (j > 0) step();
            if ((j % CPB) == 10 && (j / CPB) < 11) b[4'(j / CPB)] = tx;
            if (done === 1'b1) begin
                nd++;
                if (dj < 0) dj = j;
            end
            if (j == poke_j) begin
                load = 1'b1;
                data = poke_d;
            end else if (j == poke_j + 1) begin
                load = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [7:0] d);
        data = d;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("accept_tx", 32'(tx), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
    endtask

    task automatic frame_chk(input string tag, input logic [7:0] d);
        chk({tag, "_bits"}, 32'(bits), 32'(exp_frame(d)));
        chk({tag, "_done_at"}, done_j, FRAME);
        chk({tag, "_done_count"}, ndone, 1);
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        data = 8'h00;
        repeat (3) step();
        chk("reset_state", 32'({tx, busy, done}), 32'b100);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_after_reset", 32'({tx, busy, done}), 32'b100);
        end

        // Single frame 0x55
        send(8'h55);
        capture(FRAME + 20, -10, 8'h00, bits, done_j, ndone);
        frame_chk("f55", 8'h55);
        chk("f55_busy_end", 32'(busy), 32'd0);

        // 0x01: odd population, parity bit set when enabled
        send(8'h01);
        capture(FRAME + 20, -10, 8'h00, bits, done_j, ndone);
        frame_chk("f01", 8'h01);

        // Load while busy is ignored
        send(8'hA3);
        capture(FRAME + 20, 50, 8'hFF, bits, done_j, ndone);
        frame_chk("fA3", 8'hA3);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("ignore_no_second_frame", bad, 0);

        // Back-to-back with load held; data changes after acceptance
        data = 8'h0F;
        load = 1'b1;
        step();
        chk("b2b_accept_tx", 32'(tx), 32'd0);
        data = 8'hF0;
        capture(FRAME, -10, 8'h00, bits, done_j, ndone);
        frame_chk("f0F", 8'h0F);
        chk("b2b_done_busy", 32'(busy), 32'd0);
        step();
        load = 1'b0;
        chk("b2b_start_tx", 32'(tx), 32'd0);
        chk("b2b_start_busy", 32'(busy), 32'd1);
        capture(FRAME + 20, -10, 8'h00, bits, done_j, ndone);
        frame_chk("fF0", 8'hF0);

        // Reset at cycle 90 of a 0x00 frame, with a load on the same edge
        send(8'h00);
        capture(90, -10, 8'h00, bits, done_j, ndone);
        chk("midrst_no_done_before", ndone, 0);
        rst  = 1'b1;
        load = 1'b1;
        data = 8'h3C;
        step();
        chk("midrst_outputs", 32'({tx, busy, done}), 32'b100);
        rst  = 1'b0;
        load = 1'b0;
        capture(40, -10, 8'h00, bits, done_j, ndone);
        chk("midrst_no_done_after", ndone, 0);
        chk("midrst_line_idle", 32'(bits), 32'h7FF);
        chk("midrst_busy_low", 32'(busy), 32'd0);
        send(8'h3C);
        capture(FRAME + 20, -10, 8'h00, bits, done_j, ndone);
        frame_chk("f3C", 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
